// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command assembler.
// Contents: FSM state enum, receiver bit period and the default inter-byte timeout.
// No ports (package).
package uart_cmd_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  // clk cycles per UART bit at the system clock / baud rate in use
  localparam int CLK_PER_BIT    = 5208;
  // roughly three 10-bit byte times
  localparam int TO_CYC_DEFAULT = 156250;

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter: counts enabled cycles, flags the terminal count.
// Ports: clk/rst_n; clr_i zeroes the count (priority over en_i); en_i increments;
//        expired_o is high while count == TO_CYC-1 (never when TO_CYC == 0).
module uart_cmd_timer #(
  parameter int TO_W   = 18,
  parameter int TO_CYC = 156250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    if (TO_CYC == 0) begin : g_disabled
      assign expired_o = 1'b0;
    end else begin : g_enabled
      localparam logic [TO_W-1:0] TERM = TO_W'(TO_CYC - 1);
      assign expired_o = (cnt_q == TERM);
    end
  endgenerate

endmodule

// File: rtl/uart_cmd_assembler.sv
// Packs NUM_BYTES received UART bytes (first byte in the MSBs) into one command word.
// Ports: clk/rst_n; rx_rdy/rx_data/clr_rx_rdy receiver handshake; cmd/cmd_rdy/clr_cmd_rdy
//        command handoff; overrun (sticky, unconsumed command replaced); timeout (partial dropped).
module uart_cmd_assembler
  import uart_cmd_pkg::*;
#(
  parameter int NUM_BYTES = 2,
  parameter int TO_CYC    = TO_CYC_DEFAULT,
  parameter int TO_W      = 18
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_rdy,
  input  logic [7:0]             rx_data,
  output logic                   clr_rx_rdy,
  output logic [8*NUM_BYTES-1:0] cmd,
  output logic                   cmd_rdy,
  input  logic                   clr_cmd_rdy,
  output logic                   overrun,
  output logic                   timeout
);

  localparam int SH_W = 8 * (NUM_BYTES - 1);
  localparam logic [2:0] LAST_CNT = 3'(NUM_BYTES - 1);

  state_e                 state_q, state_d;
  logic [2:0]             byte_cnt_q, byte_cnt_d;
  logic [SH_W-1:0]        shadow_q, shadow_d;
  logic [8*NUM_BYTES-1:0] cmd_q, cmd_d;
  logic                   cmd_rdy_q, cmd_rdy_d;
  logic                   clr_rx_q, clr_rx_d;
  logic                   overrun_q, overrun_d;
  logic                   timeout_q, timeout_d;

  logic cap;
  logic to_expired;
  logic to_fire;

  // rx_rdy is still high in the cycle our clear pulse is out; ignore it then.
  assign cap     = rx_rdy & ~clr_rx_q;
  assign to_fire = (state_q == COLLECT) && to_expired && !cap;

  uart_cmd_timer #(
    .TO_W   (TO_W),
    .TO_CYC (TO_CYC)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     ((state_q == IDLE) || cap || to_fire),
    .en_i      (state_q == COLLECT),
    .expired_o (to_expired)
  );

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shadow_d   = shadow_q;
    cmd_d      = cmd_q;
    cmd_rdy_d  = cmd_rdy_q;
    overrun_d  = overrun_q;
    clr_rx_d   = cap;
    timeout_d  = to_fire;

    if (clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
      overrun_d = 1'b0;
    end

    if (cap) begin
      if (byte_cnt_q == LAST_CNT) begin
        // Completion: a set of cmd_rdy overrides a coincident acknowledge.
        cmd_d      = {shadow_q, rx_data};
        cmd_rdy_d  = 1'b1;
        if (cmd_rdy_q && !clr_cmd_rdy) begin
          overrun_d = 1'b1;
        end
        byte_cnt_d = '0;
        state_d    = IDLE;
      end else begin
        // Truncating cast keeps the newest SH_W bits of the shift.
        shadow_d   = SH_W'({shadow_q, rx_data});
        byte_cnt_d = byte_cnt_q + 3'd1;
        state_d    = COLLECT;
      end
    end else if (to_fire) begin
      state_d    = IDLE;
      byte_cnt_d = '0;
      shadow_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      shadow_q   <= '0;
      cmd_q      <= '0;
      cmd_rdy_q  <= 1'b0;
      clr_rx_q   <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shadow_q   <= shadow_d;
      cmd_q      <= cmd_d;
      cmd_rdy_q  <= cmd_rdy_d;
      clr_rx_q   <= clr_rx_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  assign clr_rx_rdy = clr_rx_q;
  assign cmd        = cmd_q;
  assign cmd_rdy    = cmd_rdy_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;

endmodule
